// File: rtl/i2c_pkg.sv
// Shared types for the I2C command sequencer.
package i2c_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ISSUE      = 3'd1,
        WAIT_START = 3'd2,
        WAIT_DONE  = 3'd3,
        RESP       = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } i2c_cmd_t;

    localparam int unsigned CMD_W = $bits(i2c_cmd_t);

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Synchronous command queue with full/empty/level; DEPTH must be a power of two.
module i2c_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok, pop_ok;

    // Pointer and level update; pointers wrap naturally at DEPTH.
    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        level_d  = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
    end

    // Control registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;

endmodule

// File: rtl/i2c_cmd_seq.sv
// Sequences queued read/write commands onto an i2c_master, one at a time.
module i2c_cmd_seq
    import i2c_pkg::*;
#(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                   sysclk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_rw,
    input  logic [6:0]             cmd_addr,
    input  logic [7:0]             cmd_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [7:0]             rsp_rdata,
    output logic                   rsp_err,
    output logic                   m_enable,
    output logic                   m_rw,
    output logic [6:0]             m_address,
    output logic [7:0]             m_wdata,
    input  logic [7:0]             m_rdata,
    input  logic                   m_busy,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    i2c_cmd_t         cmd_q, cmd_d;
    i2c_cmd_t         cmd_in, head;
    logic             m_enable_q, m_enable_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rdy_en_q;
    logic             full, empty, pop_c, push_c;

    assign cmd_in = '{rw: cmd_rw, addr: cmd_addr, wdata: cmd_wdata};
    assign push_c = cmd_valid && cmd_ready;

    i2c_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk   (sysclk),
        .rst_n (reset),
        .push  (push_c),
        .wdata (cmd_in),
        .pop   (pop_c),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    // Next-state, timeout counter and response capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        cmd_d       = cmd_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        pop_c       = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // A busy master here is left over from before; wait it out.
                if (!empty && !m_busy) begin
                    pop_c   = 1'b1;
                    cmd_d   = head;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_START;
            end
            WAIT_START: begin
                if (m_busy) begin
                    cnt_d   = '0;
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_rdata_d = 8'h00;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end
            end
            WAIT_DONE: begin
                if (!m_busy) begin
                    rsp_rdata_d = cmd_q.rw ? m_rdata : 8'h00;
                    rsp_err_d   = 1'b0;
                    state_d     = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_rdata_d = 8'h00;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                cnt_d = '0;
                if (rsp_ready) begin
                    rsp_rdata_d = 8'h00;
                    rsp_err_d   = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        m_enable_d  = (state_d == ISSUE) || (state_d == WAIT_START);
        rsp_valid_d = (state_d == RESP);
    end

    // State and registered outputs.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_q       <= '0;
            m_enable_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= 1'b0;
            rdy_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            m_enable_q  <= m_enable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rdy_en_q    <= 1'b1;
        end
    end

    assign cmd_ready = rdy_en_q && !full;
    assign m_enable  = m_enable_q;
    assign m_rw      = cmd_q.rw;
    assign m_address = cmd_q.addr;
    assign m_wdata   = cmd_q.wdata;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
